flit_reassembler: RTL and testbench
===================================

FLIT_REASSEMBLER -- requirements
Module: flit_reassembler

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter FIFO_DEPTH, default 4: completed-word buffer depth, power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 15: maximum idle cycles allowed between flits of one packet.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 f_r  input  17  router flit: [16] valid, [15:12] reserved (must be 0), [11:8] source name, [7:0] payload byte.
REQ-007 word_data  output  32  head-of-FIFO reassembled word.
REQ-008 word_src  output  4  source name of the head word.
REQ-009 word_valid  output  1  FIFO non-empty.
REQ-010 word_rd  input  1  pop request.
REQ-011 err_fmt, err_src, err_timeout  output  1 each  one-cycle error pulses.
REQ-012 overflow  output  1  sticky flag: a word was dropped.
REQ-013 drop_cnt  output  8  count of dropped words, saturating.

Function
REQ-014 A flit SHALL be processed only when f_r[16]=1; flits arrive back-to-back or with gaps, with no backpressure.
REQ-015 A flit with f_r[15:12]!=0 SHALL be discarded, SHALL abort any partial packet, and SHALL pulse err_fmt in the next cycle.
REQ-016 The FSM SHALL have two states, IDLE and COLLECT, plus a 2-bit byte index.
- IDLE + valid flit: latch src, write data to [31:24], index=1, go to COLLECT.
REQ-017 COLLECT + valid flit with the same src: write the byte at index position (1->[23:16], 2->[15:8], 3->[7:0]).
- Index 3: push {src, word} into the FIFO on that same edge, then return to IDLE.
REQ-018 COLLECT + valid flit with a different src:
- pulse err_src;
- drop the partial packet;
- treat the flit as byte 0 of a new packet.
REQ-019 The gap counter SHALL clear on every valid flit and SHALL increment each cycle in COLLECT without one.
- On reaching TIMEOUT: pulse err_timeout, drop the partial packet, return to IDLE.
- A valid flit in the same cycle the counter would reach TIMEOUT SHALL win: no timeout.
REQ-020 Latency: if the 4th flit is sampled at edge N, word_valid SHALL be 1 and word_data/word_src SHALL be valid from edge N onward (show-ahead).
REQ-021 word_rd && word_valid SHALL pop the head at the edge; word_rd with an empty FIFO SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; no drop occurs.
REQ-023 A push into a full FIFO without a pop SHALL drop the new word, set overflow, and increment drop_cnt (saturating at 255).
REQ-024 Words SHALL leave the FIFO in completion order; occupancy SHALL never exceed FIFO_DEPTH.

Reset
REQ-025 On rst, all outputs SHALL be 0 asynchronously:
- word_data, word_src, word_valid;
- all error pulses, overflow, drop_cnt.
REQ-026 On rst, the FSM SHALL go to IDLE, the index and gap counter SHALL clear, and the FIFO SHALL empty; a partial packet SHALL be lost without an error pulse.
REQ-027 Flits present during the first edge after rst deassertion SHALL be processed normally.

Structure
REQ-028 Shared package flit_pkg SHALL hold:
- FLIT_W=17;
- field bit positions (valid, reserved, src, data);
- the IDLE/COLLECT state enum.
REQ-029 The FIFO SHALL be one sub-module, sync_fifo, 36 bits wide (src+word) with parameter FIFO_DEPTH; the FSM and error logic SHALL stay in flit_reassembler.

Verification
REQ-030 Basic packet: flits 0x10ADE, 0x10AAD, 0x10ABE, 0x10AEF on consecutive cycles -> word_valid=1 after the 4th edge, word_data=0xDEADBEEF, word_src=0xA, no errors.
REQ-031 Timeout: 0x10311, 0x10322, then TIMEOUT idle cycles -> one err_timeout pulse and no word. A following 4-flit packet from src 3 assembles correctly.
REQ-032 Source change: 0x10312, 0x10334, then 0x10556, 0x10578, 0x1059A, 0x105BC -> one err_src pulse, one word 0x56789ABC with src 5.
REQ-033 Format error: 0x10312, then 0x11334 -> err_fmt pulse, partial dropped, FIFO stays empty.
REQ-034 Overflow: 5 complete packets with word_rd=0 -> overflow=1, drop_cnt=1. Four reads return the first 4 words in order; after these pops word_valid=0. Simultaneous push/pop at full -> no further drop.
REQ-035 Reset mid-packet: rst asserted after 2 flits -> all outputs 0 immediately. After release, a fresh 4-flit packet yields the correct word with no error pulses.

Source files
------------

// File: rtl/flit_pkg.sv
// Shared definitions for the flit reassembler: flit field positions, FIFO entry width, FSM states.
package flit_pkg;
  localparam int FLIT_W    = 17;
  localparam int F_VALID   = 16;
  localparam int F_RSV_HI  = 15;
  localparam int F_RSV_LO  = 12;
  localparam int F_SRC_HI  = 11;
  localparam int F_SRC_LO  = 8;
  localparam int F_DATA_HI = 7;
  localparam int F_DATA_LO = 0;
  localparam int SRC_W     = 4;
  localparam int WORD_W    = 32;
  localparam int ENTRY_W   = SRC_W + WORD_W;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == FULL_CNT);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_valid   = !w_empty;
  assign o_data    = w_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/flit_reassembler.sv
// Packs four byte-flits from one source into a 32-bit word and queues {src, word}.
// S_IDLE: waiting for byte 0 | S_COLLECT: bytes 1..3 pending, gap timer running
module flit_reassembler
  import flit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] f_r,
  output logic [WORD_W-1:0] word_data,
  output logic [SRC_W-1:0]  word_src,
  output logic              word_valid,
  input  logic              word_rd,
  output logic              err_fmt,
  output logic              err_src,
  output logic              err_timeout,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SRC_W-1:0]   r_src;
  logic [23:0]        r_bytes;
  logic [1:0]         r_idx;
  logic [GW-1:0]      r_gap;
  logic               r_err_fmt;
  logic               r_err_src;
  logic               r_err_to;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  logic               w_vld;
  logic               w_fmt_bad;
  logic               w_good;
  logic               w_same_src;
  logic               w_gap_hit;
  logic [SRC_W-1:0]   w_src;
  logic [7:0]         w_data;
  logic               w_start;
  logic               w_append;
  logic               w_push;
  logic               w_err_src;
  logic               w_err_to;
  logic               w_full;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  assign w_vld      = f_r[F_VALID];
  assign w_fmt_bad  = w_vld && (f_r[F_RSV_HI:F_RSV_LO] != 4'd0);
  assign w_good     = w_vld && !w_fmt_bad;
  assign w_src      = f_r[F_SRC_HI:F_SRC_LO];
  assign w_data     = f_r[F_DATA_HI:F_DATA_LO];
  assign w_same_src = (w_src == r_src);
  assign w_gap_hit  = (r_gap == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_good) w_state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (w_fmt_bad)                          w_state_nxt = S_IDLE;
        else if (w_good && w_same_src && r_idx == 2'd3) w_state_nxt = S_IDLE;
        else if (!w_vld && w_gap_hit)           w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start   = 1'b0;
    w_append  = 1'b0;
    w_push    = 1'b0;
    w_err_src = 1'b0;
    w_err_to  = 1'b0;
    case (r_state)
      S_IDLE: w_start = w_good;
      S_COLLECT: begin
        // A foreign source aborts the partial word and restarts at byte 0.
        w_start   = w_good && !w_same_src;
        w_err_src = w_good && !w_same_src;
        w_append  = w_good && w_same_src;
        w_push    = w_good && w_same_src && (r_idx == 2'd3);
        w_err_to  = !w_vld && w_gap_hit;
      end
      default: ;
    endcase
  end

  assign w_push_data = {r_src, r_bytes, w_data};
  assign w_drop      = w_push && w_full && !word_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src      <= '0;
      r_bytes    <= '0;
      r_idx      <= '0;
      r_gap      <= '0;
      r_err_fmt  <= 1'b0;
      r_err_src  <= 1'b0;
      r_err_to   <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err_fmt <= w_fmt_bad;
      r_err_src <= w_err_src;
      r_err_to  <= w_err_to;
      if (w_vld || r_state == S_IDLE || w_gap_hit) r_gap <= '0;
      else                                         r_gap <= r_gap + 1'b1;
      if (w_start) begin
        r_src   <= w_src;
        r_bytes <= {w_data, 16'h0000};
        r_idx   <= 2'd1;
      end else if (w_append) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd1:    r_bytes[15:8] <= w_data;
          2'd2:    r_bytes[7:0]  <= w_data;
          default: ;
        endcase
      end else if (w_fmt_bad || w_err_to) begin
        r_idx <= '0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (word_rd),
    .o_data  (w_head),
    .o_valid (word_valid),
    .o_full  (w_full)
  );

  assign word_data   = w_head[WORD_W-1:0];
  assign word_src    = w_head[ENTRY_W-1:WORD_W];
  assign err_fmt     = r_err_fmt;
  assign err_src     = r_err_src;
  assign err_timeout = r_err_to;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_flit_reassembler.sv
// Directed bench for flit_reassembler with hand-computed expected words and error pulse counts.
module tb_flit_reassembler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] f_r = '0;
  logic        word_rd = 1'b0;
  logic [31:0] word_data;
  logic [3:0]  word_src;
  logic        word_valid;
  logic        err_fmt, err_src, err_timeout, overflow;
  logic [7:0]  drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fmt  = 0;
  int n_src  = 0;
  int n_to   = 0;

  flit_reassembler #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_r         (f_r),
    .word_data   (word_data),
    .word_src    (word_src),
    .word_valid  (word_valid),
    .word_rd     (word_rd),
    .err_fmt     (err_fmt),
    .err_src     (err_src),
    .err_timeout (err_timeout),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (err_fmt === 1'b1)     n_fmt++;
    if (err_src === 1'b1)     n_src++;
    if (err_timeout === 1'b1) n_to++;
  end

  task automatic clr_err();
    n_fmt = 0; n_src = 0; n_to = 0;
  endtask

  task automatic cyc(input logic [16:0] f, input logic rd);
    @(negedge clk);
    f_r = f;
    word_rd = rd;
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [3:0] s, input logic [31:0] w, input logic rd_last);
    cyc({1'b1, 4'h0, s, w[31:24]}, 1'b0);
    cyc({1'b1, 4'h0, s, w[23:16]}, 1'b0);
    cyc({1'b1, 4'h0, s, w[15:8]},  1'b0);
    cyc({1'b1, 4'h0, s, w[7:0]},   rd_last);
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({word_data, word_src, word_valid, err_fmt, err_src, err_timeout, overflow, drop_cnt} !== 51'd0)
      $display("FAIL reset_outputs: got data=%h src=%h v=%b ef=%b es=%b et=%b ov=%b dc=%0d, want all 0",
               word_data, word_src, word_valid, err_fmt, err_src, err_timeout, overflow, drop_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clr_err();
    cyc(17'h10ADE, 0); cyc(17'h10AAD, 0); cyc(17'h10ABE, 0);
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", word_valid);
    else n_pass++;
    cyc(17'h10AEF, 0);
    n_chk++;
    if (word_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", word_valid);
    else n_pass++;
    n_chk++;
    if (word_data !== 32'hDEADBEEF) $display("FAIL basic_data: got %h want deadbeef", word_data);
    else n_pass++;
    n_chk++;
    if (word_src !== 4'hA) $display("FAIL basic_src: got %h want a", word_src);
    else n_pass++;
    cyc(17'h0, 1);
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL basic_pop_empty: got %b want 0", word_valid);
    else n_pass++;
    n_chk++;
    if (n_fmt + n_src + n_to != 0) $display("FAIL basic_no_err: got %0d pulses want 0", n_fmt + n_src + n_to);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clr_err();
    cyc(17'h10311, 0); cyc(17'h10322, 0);
    repeat (14) cyc(17'h0, 0);
    n_chk++;
    if (n_to != 0) $display("FAIL timeout_early: got %0d pulses want 0", n_to);
    else n_pass++;
    cyc(17'h0, 0);
    n_chk++;
    if (err_timeout !== 1'b1) $display("FAIL timeout_pulse: got %b want 1", err_timeout);
    else n_pass++;
    repeat (3) cyc(17'h0, 0);
    n_chk++;
    if (n_to != 1 || word_valid !== 1'b0)
      $display("FAIL timeout_once: got pulses=%0d valid=%b want 1 and 0", n_to, word_valid);
    else n_pass++;
    send_word(4'h3, 32'h11223344, 0);
    n_chk++;
    if (word_valid !== 1'b1 || word_data !== 32'h11223344 || word_src !== 4'h3)
      $display("FAIL timeout_after_word: got v=%b %h src %h want 1 11223344 src 3", word_valid, word_data, word_src);
    else n_pass++;
    cyc(17'h0, 1);
  endtask

  task automatic test_timeout_boundary();
    clr_err();
    cyc(17'h10311, 0); cyc(17'h10322, 0);
    repeat (14) cyc(17'h0, 0);
    cyc(17'h10333, 0); cyc(17'h10344, 0);
    n_chk++;
    if (n_to != 0) $display("FAIL boundary_no_timeout: got %0d pulses want 0", n_to);
    else n_pass++;
    n_chk++;
    if (word_valid !== 1'b1 || word_data !== 32'h11223344)
      $display("FAIL boundary_word: got v=%b %h want 1 11223344", word_valid, word_data);
    else n_pass++;
    cyc(17'h0, 1);
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL boundary_pop: got %b want 0", word_valid);
    else n_pass++;
  endtask

  task automatic test_src_change();
    clr_err();
    cyc(17'h10312, 0); cyc(17'h10334, 0);
    cyc(17'h10556, 0);
    n_chk++;
    if (err_src !== 1'b1) $display("FAIL src_pulse: got %b want 1", err_src);
    else n_pass++;
    cyc(17'h10578, 0); cyc(17'h1059A, 0); cyc(17'h105BC, 0);
    n_chk++;
    if (n_src != 1 || n_fmt + n_to != 0)
      $display("FAIL src_err_count: got src=%0d other=%0d want 1 and 0", n_src, n_fmt + n_to);
    else n_pass++;
    n_chk++;
    if (word_valid !== 1'b1 || word_data !== 32'h56789ABC || word_src !== 4'h5)
      $display("FAIL src_word: got v=%b %h src %h want 1 56789abc src 5", word_valid, word_data, word_src);
    else n_pass++;
    cyc(17'h0, 1);
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL src_single_word: got %b want 0", word_valid);
    else n_pass++;
  endtask

  task automatic test_fmt();
    clr_err();
    cyc(17'h10312, 0); cyc(17'h11334, 0);
    n_chk++;
    if (err_fmt !== 1'b1) $display("FAIL fmt_pulse: got %b want 1", err_fmt);
    else n_pass++;
    cyc(17'h10356, 0);
    n_chk++;
    if (err_fmt !== 1'b0) $display("FAIL fmt_pulse_width: got %b want 0", err_fmt);
    else n_pass++;
    cyc(17'h10378, 0); cyc(17'h1039A, 0);
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL fmt_partial_dropped: got %b want 0", word_valid);
    else n_pass++;
    cyc(17'h103BC, 0);
    n_chk++;
    if (word_valid !== 1'b1 || word_data !== 32'h56789ABC || word_src !== 4'h3 || n_fmt != 1)
      $display("FAIL fmt_next_word: got v=%b %h src %h fmt=%0d want 1 56789abc src 3 fmt=1",
               word_valid, word_data, word_src, n_fmt);
    else n_pass++;
    cyc(17'h0, 1);
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w;
    for (int k = 1; k <= 5; k++) send_word(4'(k), 32'h11111111 * k, 0);
    n_chk++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1 || word_valid !== 1'b1)
      $display("FAIL ovf_flags: got ov=%b dc=%0d v=%b want 1 1 1", overflow, drop_cnt, word_valid);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      exp_w = 32'h11111111 * i;
      n_chk++;
      if (word_data !== exp_w || word_src !== 4'(i))
        $display("FAIL ovf_read%0d: got %h src %h want %h src %h", i, word_data, word_src, exp_w, 4'(i));
      else n_pass++;
      cyc(17'h0, 1);
    end
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", word_valid);
    else n_pass++;
    cyc(17'h0, 1);
    for (int k = 6; k <= 9; k++) send_word(4'(k), 32'h11111111 * k, 0);
    send_word(4'hA, 32'hAAAAAAAA, 1);
    n_chk++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1)
      $display("FAIL ovf_pushpop_full: got dc=%0d ov=%b want 1 1", drop_cnt, overflow);
    else n_pass++;
    for (int i = 7; i <= 10; i++) begin
      exp_w = 32'h11111111 * i;
      n_chk++;
      if (word_valid !== 1'b1 || word_data !== exp_w || word_src !== 4'(i))
        $display("FAIL ovf_refill%0d: got v=%b %h src %h want 1 %h src %h",
                 i, word_valid, word_data, word_src, exp_w, 4'(i));
      else n_pass++;
      cyc(17'h0, 1);
    end
    n_chk++;
    if (word_valid !== 1'b0) $display("FAIL ovf_final_empty: got %b want 0", word_valid);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    send_word(4'h1, 32'hCAFEF00D, 0);
    cyc(17'h10312, 0); cyc(17'h10334, 0);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({word_data, word_src, word_valid, err_fmt, err_src, err_timeout, overflow, drop_cnt} !== 51'd0)
      $display("FAIL rst_async: got data=%h src=%h v=%b ef=%b es=%b et=%b ov=%b dc=%0d, want all 0",
               word_data, word_src, word_valid, err_fmt, err_src, err_timeout, overflow, drop_cnt);
    else n_pass++;
    @(negedge clk);
    clr_err();
    f_r = 17'h10711;
    word_rd = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #2;
    cyc(17'h10722, 0); cyc(17'h10733, 0); cyc(17'h10744, 0);
    n_chk++;
    if (word_valid !== 1'b1 || word_data !== 32'h11223344 || word_src !== 4'h7)
      $display("FAIL rst_fresh_word: got v=%b %h src %h want 1 11223344 src 7", word_valid, word_data, word_src);
    else n_pass++;
    cyc(17'h0, 0);
    n_chk++;
    if (n_fmt + n_src + n_to != 0)
      $display("FAIL rst_no_err: got %0d pulses want 0", n_fmt + n_src + n_to);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_timeout_boundary();
    test_src_change();
    test_fmt();
    test_overflow();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
